alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes the low 64 bits of a 64x64 unsigned/two's-complement product. It sequences the shared 64-bit ripple `alu` through a shift-add loop: it drives the ALU operand and control inputs and captures the ALU result each cycle. It sits beside the execute stage and is started by the MUL decode path. While it runs, it owns the ALU's inputs; the pipeline stalls on `busy`.

---
 rtl/alu_mul_sequencer.sv | 100 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller: sequences the shared ripple ALU to form the
// low WIDTH bits of op_a*op_b, stopping early once the remaining multiplier is zero.
module alu_mul_sequencer #(
    parameter int          WIDTH     = 64,
    parameter logic [2:0]  ADD_CNTRL = 3'b010
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             prod_zero,
    output logic             prod_negative,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [6:0]       count;
    logic             last_iter;

    // Stop when no multiplier bits remain after this add, or after WIDTH adds.
    assign last_iter = ((mplier >> 1) == '0) || (count == 7'(WIDTH - 1));

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_cntrl = ADD_CNTRL;
        if (state == RUN) begin
            alu_a = acc;
            alu_b = mplier[0] ? mcand : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            product       <= '0;
            prod_zero     <= 1'b1;
            prod_negative <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 7'd1;
                    if (last_iter) begin
                        product       <= alu_result;
                        prod_zero     <= (alu_result == '0);
                        prod_negative <= alu_result[WIDTH-1];
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: behavioural ALU, arithmetic reference
// model, directed cases plus randomized operands.
module tb_alu_mul_sequencer;

    localparam logic [2:0] ADD = 3'b010;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        prod_zero;
    logic        prod_negative;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_product;

    alu_mul_sequencer #(.WIDTH(64), .ADD_CNTRL(ADD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op_a(op_a),
        .op_b(op_b),
        .busy(busy),
        .done(done),
        .product(product),
        .prod_zero(prod_zero),
        .prod_negative(prod_negative),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_cntrl(alu_cntrl),
        .alu_result(alu_result)
    );

    // Shared ALU: only the add code is meaningful; other codes subtract.
    assign alu_result = (alu_cntrl == ADD) ? alu_a + alu_b : alu_a - alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input logic [63:0] b);
        int n = 1;
        for (int i = 0; i < 64; i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic check_idle_alu(input string tag);
        check({tag, "_idle_alu_a"}, alu_a, 64'd0);
        check({tag, "_idle_alu_b"}, alu_b, 64'd0);
        check({tag, "_idle_alu_cntrl"}, {61'd0, alu_cntrl}, {61'd0, ADD});
    endtask

    task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input string tag);
        logic [63:0] exp_p;
        int n;
        int cyc;
        int busy_cycles;
        int done_cnt;
        int done_cyc;
        exp_p = a * b;
        n = run_len(b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        busy_cycles = 0;
        done_cnt = 0;
        done_cyc = 0;
        check({tag, "_run_cntrl"}, {61'd0, alu_cntrl}, {61'd0, ADD});
        check({tag, "_product_held"}, product, last_product);
        while (busy && cyc < 200) begin
            busy_cycles++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(n + 1));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(n + 1));
        check({tag, "_product"}, product, exp_p);
        check({tag, "_zero"}, {63'd0, prod_zero}, {63'd0, exp_p == 64'd0});
        check({tag, "_neg"}, {63'd0, prod_negative}, {63'd0, exp_p[63]});
        check_idle_alu(tag);
        last_product = exp_p;
    endtask

    initial begin
        int cyc;
        int done_seen;
        reset_n = 1'b0;
        start   = 1'b1;
        op_a    = 64'd5;
        op_b    = 64'd9;
        last_product = 64'd0;

        // Reset held with start high: nothing may begin.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_zero", {63'd0, prod_zero}, 64'd1);
        check("rst_neg", {63'd0, prod_negative}, 64'd0);
        check_idle_alu("rst");

        do_mul(64'd3, 64'd5, "m3x5");
        do_mul(64'h1234, 64'd0, "opb0");
        do_mul('1, '1, "allones");
        do_mul(64'h8000_0000_0000_0000, 64'd2, "wrap");
        do_mul(-64'sd7, 64'd3, "neg7x3");
        check("neg7x3_value", product, 64'hFFFF_FFFF_FFFF_FFEB);

        // start held high through DONE: re-accepted only after one IDLE cycle.
        @(negedge clk);
        op_a  = 64'd11;
        op_b  = 64'd1;
        start = 1'b1;
        @(posedge clk); #1;
        check("hold_busy_e0", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        check("hold_done_e1", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        check("hold_idle_e2", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("hold_reaccept_e3", {63'd0, busy}, 64'd1);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("hold_finish", {63'd0, busy}, 64'd0);
        check("hold_product", product, 64'd11);
        last_product = 64'd11;

        for (int i = 0; i < 20; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            do_mul(ra, rb, $sformatf("rand%0d", i));
        end

        // Abort: stray start mid-run is ignored, reset at cycle 20 kills the run.
        @(negedge clk);
        op_a  = 64'h0123_4567_89AB_CDEF;
        op_b  = '1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        done_seen = 0;
        while (cyc < 20) begin
            if (done) done_seen++;
            if (cyc == 10) start = 1'b1;
            if (cyc == 11) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_busy_before_rst", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        if (done) done_seen++;
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_zero", {63'd0, prod_zero}, 64'd1);
        check("abort_neg", {63'd0, prod_negative}, 64'd0);
        last_product = 64'd0;
        do_mul(64'd6, 64'd7, "m6x7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
